serial_add_seq: RTL and testbench
=================================

Name: serial_add_seq

Overview:
- Bit-serial add sequencer sitting directly upstream of the 1-bit adder cell (addbit).
- Takes two WIDTH-bit operands plus a carry-in. Presents one bit pair per cycle, LSB first, on the cell's a/b/ci inputs.
- Captures the cell's sum/co back each cycle and assembles the WIDTH-bit result and final carry-out.
- Lets the gate/RTL 1-bit adder be exercised as a multi-bit adder under a clocked harness.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an add; sampled on clk rising edge.
- op_a  input  WIDTH  operand A; captured when start is accepted.
- op_b  input  WIDTH  operand B; captured when start is accepted.
- cin  input  1  carry-in; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result/cout valid.
- result  output  WIDTH  sum; holds until the next accepted start.
- cout  output  1  final carry; holds like result.
- add_a  output  1  to adder cell input a.
- add_b  output  1  to adder cell input b.
- add_ci  output  1  to adder cell input ci.
- add_sum  input  1  from adder cell sum; combinational response to add_a/add_b/add_ci, zero delay.
- add_co  input  1  from adder cell co; same timing as add_sum.

Behaviour:
- Clock/reset: one clock (clk); rst is synchronous and active-high.
- Reset state:
  - state=IDLE; busy=0, done=0, result=0, cout=0, add_a/add_b/add_ci=0.
  - Internal shift registers, carry and bit counter cleared.
  - rst has priority over start, including mid-RUN: the operation is abandoned with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch op_a, op_b into shift regs sa, sb; carry_q<=cin; cnt<=0; result<=0; go to RUN.
  - start=0 → stay.
- RUN:
  - add_a=sa[0], add_b=sb[0], add_ci=carry_q. All three come straight from registers, so no combinational path from start/op_*.
  - Each edge: result<={add_sum, result[WIDTH-1:1]}; carry_q<=add_co; sa<=sa>>1; sb<=sb>>1; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: cout<=add_co and go to DONE.
  - start is ignored throughout RUN: no restart, no queueing.
- DONE:
  - done=1 for exactly this cycle; busy=0.
  - start=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise go to IDLE.
- Outside RUN: add_a/add_b/add_ci driven 0.
- Latency: start sampled at edge N → busy high for cycles N+1..N+WIDTH; done high in the cycle after edge N+WIDTH. Throughput is one add per WIDTH+1 cycles.
- Arithmetic: {cout,result} = op_a + op_b + cin, modulo 2^(WIDTH+1). The counter is $clog2(WIDTH+1) bits wide, with no wrap before WIDTH-1.
- WIDTH=1: RUN lasts one cycle; result = op_a^op_b^cin.
- X on add_sum/add_co propagates into result/cout unchanged (no masking).

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit), reset 0.
  - At the final RUN edge, ovf<=add_co ^ carry_q. carry_q at that point is the carry into the MSB, so ovf is two's-complement signed overflow.
  - ovf updates and holds with result/cout.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, op_a=8'h5A, op_b=8'h3C, cin=0, start pulse → busy high 8 cycles; done one cycle; result=8'h96, cout=0; add_a sequence LSB-first 0,1,0,1,1,0,1,0.
- op_a=8'hFF, op_b=8'h01, cin=0 → result=8'h00, cout=1. op_a=8'hFF, op_b=8'hFF, cin=1 → result=8'hFF, cout=1.
- Start 8'h12+8'h34, then re-assert start with 8'hFF+8'hFF at RUN cycle 3 → ignored; result=8'h46, cout=0, exactly one done.
- start held high continuously with 8'h01+8'h01 → done every 9 cycles, result=8'h02 each time, busy low only in DONE cycles.
- rst asserted at RUN cycle 4 → next cycle busy=0, result=0, cout=0, no done pulse; a fresh start completes normally.
- With SERIAL_ADD_OVF_EN: 8'h7F+8'h01 → result=8'h80, cout=0, ovf=1. 8'h80+8'h80 → result=8'h00, cout=1, ovf=1. 8'hFF+8'h01 → ovf=0.

Source files
------------

// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial sequencer that drives an external 1-bit adder cell LSB first
// and assembles a WIDTH-bit sum. Define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module serial_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             add_a,
    output logic             add_b,
    output logic             add_ci,
    input  logic             add_sum,
`ifdef SERIAL_ADD_OVF_EN
    input  logic             add_co,
    output logic             ovf
`else
    input  logic             add_co
`endif
);

    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] res_sh;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        add_a    = 1'b0;
        add_b    = 1'b0;
        add_ci   = 1'b0;
        accept   = 1'b0;
        last     = (cnt == LAST);
        // The concatenation shift keeps WIDTH=1 legal (no empty result slice).
        res_sh   = WIDTH'({add_sum, result} >> 1);
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                add_a  = sa[0];
                add_b  = sb[0];
                add_ci = carry_q;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa      <= '0;
            sb      <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
            result  <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            sa      <= op_a;
            sb      <= op_b;
            carry_q <= cin;
            cnt     <= '0;
            result  <= '0;
        end else if (state == RUN) begin
            result  <= res_sh;
            carry_q <= add_co;
            sa      <= sa >> 1;
            sb      <= sb >> 1;
            cnt     <= cnt + CW'(1);
            if (last) begin
                cout <= add_co;
`ifdef SERIAL_ADD_OVF_EN
                // carry_q here is the carry into the MSB
                ovf  <= add_co ^ carry_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq: vector table, hand-written corner sequences,
// random operands against plain-arithmetic expectations, plus a WIDTH=1 instance.
module tb_serial_add_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [W-1:0] op_a, op_b, result;
    logic         busy, done, cout, add_a, add_b, add_ci, add_sum, add_co;
    logic         start1, a1, b1, cin1, busy1, done1, res1, cout1;
    logic         x_a, x_b, x_ci, x_sum, x_co;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf, ovf1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // 1-bit adder cells attached to each sequencer
    assign add_sum = add_a ^ add_b ^ add_ci;
    assign add_co  = (add_a & add_b) | (add_ci & (add_a ^ add_b));
    assign x_sum   = x_a ^ x_b ^ x_ci;
    assign x_co    = (x_a & x_b) | (x_ci & (x_a ^ x_b));

    serial_add_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
        .busy(busy), .done(done), .result(result), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_sum(add_sum),
`ifdef SERIAL_ADD_OVF_EN
        .add_co(add_co), .ovf(ovf)
`else
        .add_co(add_co)
`endif
    );

    serial_add_seq #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_a(a1), .op_b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .result(res1), .cout(cout1),
        .add_a(x_a), .add_b(x_b), .add_ci(x_ci), .add_sum(x_sum),
`ifdef SERIAL_ADD_OVF_EN
        .add_co(x_co), .ovf(ovf1)
`else
        .add_co(x_co)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Starts one add and follows it to its done pulse; returns in the done cycle.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                           output logic [W-1:0] r, output logic co, output int busy_n,
                           output logic [W-1:0] abits, output logic ok);
        @(negedge clk);
        op_a = a; op_b = b; cin = ci; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        busy_n = 0;
        ok     = 1'b0;
        abits  = '0;
        for (int i = 0; i < 50; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) begin
                if (busy_n < W) abits[busy_n] = add_a;
                busy_n++;
            end
            @(negedge clk);
        end
        r  = result;
        co = cout;
    endtask

    logic [W-1:0] r, ab, ra, rb;
    logic         co, ok, rc;
    logic [W:0]   exp9;
    logic [2:0]   kv;
    logic [1:0]   exp2;
    int           bn, nd, last_i, bad, ssum;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_adder_in", {add_a, add_b, add_ci}, 3'b000);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", ovf, 1'b0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_add(vecs[i].a, vecs[i].b, vecs[i].ci, r, co, bn, ab, ok);
            chk("vec_done_seen", ok, 1'b1);
            chk("vec_result", r, vecs[i].r);
            chk("vec_cout", co, vecs[i].co);
            chk("vec_busy_cycles", bn, W);
            chk("vec_add_a_seq", ab, vecs[i].a);
`ifdef SERIAL_ADD_OVF_EN
            chk("vec_ovf", ovf, vecs[i].ov);
`endif
            @(negedge clk);
            chk("vec_done_one_cycle", done, 1'b0);
            chk("vec_result_hold", result, vecs[i].r);
        end

        // restart attempt during RUN must be ignored
        @(negedge clk);
        op_a = 8'h12; op_b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        op_a = 8'hFF; op_b = 8'hFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                nd++;
                r = result; co = cout;
            end
            @(negedge clk);
        end
        chk("ignore_done_count", nd, 1);
        chk("ignore_result", r, 8'h46);
        chk("ignore_cout", co, 1'b0);

        // start held high: back-to-back adds every WIDTH+1 cycles
        op_a = 8'h01; op_b = 8'h01; cin = 1'b0; start = 1'b1;
        nd = 0; last_i = 0; bad = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy == done) bad++;
            if (done) begin
                nd++;
                chk("cont_result", result, 8'h02);
                chk("cont_period", i - last_i, W + 1);
                last_i = i;
            end
        end
        start = 1'b0;
        chk("cont_done_count", nd, 4);
        chk("cont_busy_vs_done", bad, 0);
        repeat (12) @(negedge clk);

        // reset in the middle of RUN abandons the add
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_result", result, '0);
        chk("midrst_cout", cout, 1'b0);
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("midrst_no_done", nd, 0);
        run_add(8'hFF, 8'h01, 1'b0, r, co, bn, ab, ok);
        chk("postrst_done_seen", ok, 1'b1);
        chk("postrst_sum", {co, r}, 9'h100);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            run_add(ra, rb, rc, r, co, bn, ab, ok);
            exp9 = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            chk("rand_done_seen", ok, 1'b1);
            chk("rand_sum", {co, r}, exp9);
`ifdef SERIAL_ADD_OVF_EN
            ssum = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
            chk("rand_ovf", ovf, (ssum > 127 || ssum < -128) ? 1'b1 : 1'b0);
`endif
        end

        // WIDTH=1: single RUN cycle, exhaustive operands
        for (int k = 0; k < 8; k++) begin
            kv = 3'(k);
            @(negedge clk);
            a1 = kv[0]; b1 = kv[1]; cin1 = kv[2]; start1 = 1'b1;
            @(negedge clk); start1 = 1'b0;
            chk("w1_busy", busy1, 1'b1);
            @(negedge clk);
            exp2 = 2'(kv[0]) + 2'(kv[1]) + 2'(kv[2]);
            chk("w1_done", done1, 1'b1);
            chk("w1_sum", {cout1, res1}, exp2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
